// File: rtl/telemetry_frame_tx.sv
// Periodic telemetry framer: snapshots N_CH channel bytes on each period tick and streams HEADER + channels to the UART Tx.
// Optional feature macro TELEM_CHECKSUM_EN appends a two's-complement checksum byte after the last channel.
module telemetry_frame_tx #(
    parameter int          N_CH   = 12,
    parameter int          PERIOD = 6000000,
    parameter int          PER_W  = 23,
    parameter logic [7:0]  HEADER = 8'hF7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stp,
    input  logic                eoTx,
    input  logic [8*N_CH-1:0]   ch_data,
    output logic [7:0]          DATA_Tx,
    output logic                stTx,
    output logic                eop,
    output logic                busy,
    output logic                ovr
);

    localparam int POS_W = $clog2(N_CH + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND,
        ST_WAIT_EOT,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [PER_W-1:0]    r_cnt;
    logic [POS_W-1:0]    r_pos;
    logic [POS_W-1:0]    w_nextPos;
    logic [8*N_CH-1:0]   r_snap;
    logic [7:0]          r_data;
    logic [7:0]          w_nextData;
    logic [7:0]          w_chByte;
    logic                r_stTx;
    logic                r_eop;
    logic                r_busy;
    logic                r_ovr;
    logic                w_tick;
    logic                w_load;
    logic                w_capture;
    logic                w_frameActive;
`ifdef TELEM_CHECKSUM_EN
    logic [7:0]          r_sum;
    logic [7:0]          w_nextSum;
`endif

    assign w_tick = stp && (r_cnt == PER_W'(PERIOD - 1));
    assign w_frameActive = (r_state == ST_SEND) || (r_state == ST_WAIT_EOT) || (r_state == ST_DONE);

    // Free-running period counter; only stp gates it, frame state never does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!stp || (r_cnt == PER_W'(PERIOD - 1))) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_pos is the position of the byte currently on DATA_Tx (0 = header), so it also names the next channel.
    always_comb begin
        w_chByte = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_pos == POS_W'(i)) begin
                w_chByte = r_snap[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextPos   = r_pos;
        w_nextData  = r_data;
        w_load      = 1'b0;
        w_capture   = 1'b0;
`ifdef TELEM_CHECKSUM_EN
        w_nextSum   = r_sum;
`endif
        case (r_state)
            ST_IDLE: begin
                if (stp) begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_tick) begin
                    w_nextState = ST_SEND;
                    w_capture   = 1'b1;
                    w_load      = 1'b1;
                    w_nextData  = HEADER;
                    w_nextPos   = '0;
`ifdef TELEM_CHECKSUM_EN
                    w_nextSum   = '0;
`endif
                end else if (!stp) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_SEND: begin
                w_nextState = ST_WAIT_EOT;
            end
            ST_WAIT_EOT: begin
                if (eoTx) begin
                    if (r_pos < POS_W'(N_CH)) begin
                        w_nextState = ST_SEND;
                        w_load      = 1'b1;
                        w_nextData  = w_chByte;
                        w_nextPos   = r_pos + 1'b1;
`ifdef TELEM_CHECKSUM_EN
                        w_nextSum   = r_sum + w_chByte;
                    end else if (r_pos == POS_W'(N_CH)) begin
                        w_nextState = ST_SEND;
                        w_load      = 1'b1;
                        w_nextData  = ~r_sum + 8'd1;
                        w_nextPos   = r_pos + 1'b1;
`endif
                    end else begin
                        w_nextState = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_nextState = stp ? ST_WAIT : ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pos   <= '0;
            r_snap  <= '0;
            r_data  <= '0;
            r_stTx  <= 1'b0;
            r_eop   <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef TELEM_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_state <= w_nextState;
            r_pos   <= w_nextPos;
            r_data  <= w_nextData;
            r_stTx  <= w_load;
            r_eop   <= (w_nextState == ST_DONE);
            r_busy  <= (w_nextState == ST_SEND) || (w_nextState == ST_WAIT_EOT);
            r_ovr   <= w_tick && w_frameActive;
            if (w_capture) begin
                r_snap <= ch_data;
            end
`ifdef TELEM_CHECKSUM_EN
            r_sum   <= w_nextSum;
`endif
        end
    end

    assign DATA_Tx = r_data;
    assign stTx    = r_stTx;
    assign eop     = r_eop;
    assign busy    = r_busy;
    assign ovr     = r_ovr;

endmodule

// File: tb/tb_telemetry_frame_tx.sv
// Directed self-checking bench for telemetry_frame_tx (N_CH=4, PERIOD=20); honours TELEM_CHECKSUM_EN when defined.
module tb_telemetry_frame_tx;

    localparam int N_CH   = 4;
    localparam int PERIOD = 20;
`ifdef TELEM_CHECKSUM_EN
    localparam int LEN        = N_CH + 2;
    localparam int EXP_OVR    = 7;
    localparam int OVR_GAP    = 160;
`else
    localparam int LEN        = N_CH + 1;
    localparam int EXP_OVR    = 6;
    localparam int OVR_GAP    = 140;
`endif

    logic               clk;
    logic               rst;
    logic               stp;
    logic               eoTx;
    logic [8*N_CH-1:0]  ch_data;
    logic [7:0]         DATA_Tx;
    logic               stTx;
    logic               eop;
    logic               busy;
    logic               ovr;

    int checks     = 0;
    int errors     = 0;
    int cycleCnt   = 0;
    int stTxCnt    = 0;
    int ovrCnt     = 0;
    int eopCnt     = 0;

    telemetry_frame_tx #(
        .N_CH   (N_CH),
        .PERIOD (PERIOD),
        .PER_W  (5),
        .HEADER (8'hF7)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .stp     (stp),
        .eoTx    (eoTx),
        .ch_data (ch_data),
        .DATA_Tx (DATA_Tx),
        .stTx    (stTx),
        .eop     (eop),
        .busy    (busy),
        .ovr     (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters see the previous cycle's outputs at each rising edge.
    always @(posedge clk) begin
        cycleCnt++;
        if (stTx === 1'b1) stTxCnt++;
        if (ovr === 1'b1)  ovrCnt++;
        if (eop === 1'b1)  eopCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic e, input logic [31:0] d);
        rst     = r;
        stp     = s;
        eoTx    = e;
        ch_data = d;
    endtask

    task automatic waitStTx(output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (stTx === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulseEoTx();
        eoTx = 1'b1;
        @(negedge clk);
        eoTx = 1'b0;
    endtask

    // Plays the UART side for one frame: eoTx comes 'delay' cycles after each stTx.
    task automatic sendFrame(input string tag, input logic [31:0] chWord, input int delay,
                             input bit changeData, input logic [31:0] newData,
                             input bit dropStp, output int hdrCycle);
        logic [7:0] bytes [N_CH + 2];
        logic [7:0] sum;
        bit         found;
        int         waited;
        bytes[0] = 8'hF7;
        sum = 8'h00;
        for (int i = 0; i < N_CH; i++) begin
            bytes[i + 1] = chWord[8*i +: 8];
            sum = sum + chWord[8*i +: 8];
        end
        bytes[N_CH + 1] = 8'h00 - sum;
        hdrCycle = 0;
        for (int b = 0; b < LEN; b++) begin
            waitStTx(found);
            checkOutput($sformatf("%s_stTx%0d", tag, b), {31'd0, found}, 32'd1);
            if (b == 0) hdrCycle = cycleCnt;
            checkOutput($sformatf("%s_byte%0d", tag, b), {24'd0, DATA_Tx}, {24'd0, bytes[b]});
            checkOutput($sformatf("%s_busy%0d", tag, b), {31'd0, busy}, 32'd1);
            waited = 0;
            if (b == 0 && changeData) begin
                @(negedge clk);
                ch_data = newData;
                waited = 1;
            end
            if (b == 1 && dropStp) stp = 1'b0;
            repeat (delay - waited) @(negedge clk);
            pulseEoTx();
        end
        checkOutput($sformatf("%s_eop", tag), {31'd0, eop}, 32'd1);
        checkOutput($sformatf("%s_busyDone", tag), {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput($sformatf("%s_eopOnce", tag), {31'd0, eop}, 32'd0);
    endtask

    initial begin
        int  h0, h1, h2, h3, s0, snapSt, snapOvr, snapEop;
        bit  found;
        logic [7:0] f5 [3];

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h44332211);
        repeat (2) @(negedge clk);
        checkOutput("rst_data", {24'd0, DATA_Tx}, 32'd0);
        checkOutput("rst_stTx", {31'd0, stTx}, 32'd0);
        checkOutput("rst_eop",  {31'd0, eop},  32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_ovr",  {31'd0, ovr},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1 changes ch_data right after its header; the snapshot must protect it.
        stp = 1'b1;
        s0 = cycleCnt;
        sendFrame("f1", 32'h44332211, 2, 1'b1, 32'hAABBCCDD, 1'b0, h0);
        checkOutput("f1_latency", h0 - s0, PERIOD);
        sendFrame("f2", 32'hAABBCCDD, 2, 1'b0, 32'h0, 1'b0, h1);
        checkOutput("f2_gap", h1 - h0, PERIOD);
        checkOutput("ovr_none", ovrCnt, 32'd0);

        // Slow UART: frame overruns the period, ticks are dropped and reported.
        snapSt  = stTxCnt;
        snapOvr = ovrCnt;
        sendFrame("f3", 32'hAABBCCDD, 25, 1'b0, 32'h0, 1'b0, h2);
        checkOutput("f3_gap", h2 - h1, PERIOD);
        checkOutput("f3_ovrCount", ovrCnt - snapOvr, EXP_OVR);
        checkOutput("f3_stTxCount", stTxCnt - snapSt, LEN);

        // stp dropped after the second byte: frame finishes, then silence.
        sendFrame("f4", 32'hAABBCCDD, 2, 1'b0, 32'h0, 1'b1, h3);
        checkOutput("f4_gap", h3 - h2, OVR_GAP);
        snapSt = stTxCnt;
        repeat (60) @(negedge clk);
        checkOutput("idle_stTx", stTxCnt - snapSt, 32'd0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        stp = 1'b1;
        s0 = cycleCnt;
        f5[0] = 8'hF7;
        f5[1] = 8'hDD;
        f5[2] = 8'hCC;
        for (int b = 0; b < 3; b++) begin
            waitStTx(found);
            checkOutput($sformatf("f5_stTx%0d", b), {31'd0, found}, 32'd1);
            if (b == 0) checkOutput("f5_restart", cycleCnt - s0, PERIOD);
            checkOutput($sformatf("f5_byte%0d", b), {24'd0, DATA_Tx}, {24'd0, f5[b]});
            if (b < 2) begin
                repeat (2) @(negedge clk);
                pulseEoTx();
            end
        end

        // Reset lands while byte 2 is in flight.
        @(negedge clk);
        snapEop = eopCnt;
        rst = 1'b1;
        stp = 1'b0;
        #1;
        checkOutput("mid_rst_data", {24'd0, DATA_Tx}, 32'd0);
        checkOutput("mid_rst_stTx", {31'd0, stTx}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        snapSt = stTxCnt;
        @(negedge clk);
        pulseEoTx();
        repeat (30) @(negedge clk);
        checkOutput("post_rst_stTx", stTxCnt - snapSt, 32'd0);
        checkOutput("post_rst_eop", eopCnt - snapEop, 32'd0);
        checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("post_rst_data", {24'd0, DATA_Tx}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/telemetry_frame_tx.md
# telemetry_frame_tx

Periodic telemetry framer that snapshots N_CH byte channels and streams them, one byte per UART handshake, as a header-prefixed frame to the byte transmitter. It sits between the control datapath (position, error, speeds, sensor bytes) and the UART Tx block. It replaces the fixed 12-channel sender with a parametrised channel count and period, a coherent snapshot, overrun reporting and an optional checksum byte.

## Interface
Parameters:
- N_CH, 12, number of 8-bit channels per frame (1..30)
- PERIOD, 6000000, frame period in clk cycles (≥ 2)
- PER_W, 23, period counter width; must satisfy 2^PER_W ≥ PERIOD
- HEADER, 8'hF7, first byte of every frame

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stp  in  1  enable periodic transmission (level)
- eoTx  in  1  UART Tx end-of-byte pulse, one cycle
- ch_data  in  8*N_CH  channel bytes; channel i = ch_data[8*i+7:8*i]
- DATA_Tx  out  8  byte to UART Tx, registered
- stTx  out  1  start-of-byte pulse to UART Tx, one cycle
- eop  out  1  end-of-frame pulse, one cycle
- busy  out  1  high while a frame is in progress
- ovr  out  1  one-cycle pulse when a period tick is dropped

## Operation
- Reset values: DATA_Tx=0, stTx=0, eop=0, busy=0, ovr=0, period counter=0, state IDLE, index=0, snapshot=0.
- Period counter: cleared while stp=0; while stp=1 counts 0..PERIOD-1 and wraps; tick = (count==PERIOD-1 && stp). Counter runs independently of frame state.
- Frame: HEADER, ch0, ch1, …, ch(N_CH-1) [, CHK]. Length N_CH+1 (N_CH+2 with checksum).
- States:
  - IDLE: stp=0. stp=1 → WAIT.
  - WAIT: on tick → SEND: capture all of ch_data into snapshot, DATA_Tx←HEADER, stTx←1, index←0, busy←1. stp=0 → IDLE.
  - SEND: single cycle (stTx high) → WAIT_EOT.
  - WAIT_EOT: eoTx=1 and bytes remain → SEND with DATA_Tx←next byte from snapshot, stTx←1, index+1. eoTx=1 on last byte → DONE.
  - DONE: eop=1, busy=0 for one cycle → WAIT if stp=1, else IDLE.
- Frame bytes come only from the snapshot; ch_data changes during a frame never affect it.
- stp dropped mid-frame: frame completes; then IDLE.
- tick while busy (SEND/WAIT_EOT/DONE): tick dropped, ovr=1 for that cycle + 1 (registered); no queued frame.
- eoTx outside WAIT_EOT: ignored. eoTx in the same cycle as stTx: ignored.
- DATA_Tx holds its value until the next stTx load.

## Timing
- tick in cycle t → stTx=1 and DATA_Tx=HEADER in cycle t+1; snapshot = ch_data sampled at edge ending cycle t.
- eoTx in cycle k (WAIT_EOT, not last) → stTx=1 with next byte in cycle k+1.
- eoTx in cycle k on last byte → eop=1, busy=0 in cycle k+1.
- Minimum frame duration = (frame length)·(UART byte time) + frame length + 1 cycles; PERIOD must exceed it to avoid ovr.
- ovr pulses in cycle t+1 for a dropped tick in cycle t.
- rst asserted anytime: all outputs to reset values asynchronously; frame abandoned; no eop.

## Configuration
- TELEM_CHECKSUM_EN defined: after the last channel byte an extra byte CHK = (−Σ snapshot channel bytes) mod 256 (header excluded) is sent; Σ(channel bytes)+CHK ≡ 0 mod 256. Accumulated as bytes are loaded; eop follows the checksum's eoTx.
- Undefined: no checksum logic; frame ends after channel N_CH-1.

## Test plan
- N_CH=4, PERIOD=20, ch_data=32'h44332211, stp=1, eoTx returned 3 cycles after each stTx → bytes F7,11,22,33,44; eop once after fifth eoTx; busy low again; next HEADER stTx 20 cycles after the first.
- Same config, ch_data changed to 32'hAABBCCDD one cycle after header stTx → frame still carries 11,22,33,44; next frame carries DD,CC,BB,AA.
- eoTx delayed 25 cycles per byte (frame longer than PERIOD) → ovr pulses once per dropped tick, no extra stTx, no frame corruption.
- stp dropped after second byte → remaining bytes sent, eop, then no further stTx; stp re-raised → first header after PERIOD cycles.
- rst pulse during WAIT_EOT of byte 2 → DATA_Tx=0, stTx=0, busy=0, no eop; spurious eoTx afterwards ignored.
- TELEM_CHECKSUM_EN, ch_data=32'h44332211 → sixth byte 8'h56 (0x100−0xAA), eop after its eoTx.
